dht11_sensor_emu: RTL
=====================

Name: dht11_sensor_emu

Overview:
Synthesizable DHT11 sensor emulator: the responder end of the single-wire DHT11 protocol whose host side is the team's dht11 reader.
- Detects a host start pulse on the open-drain bus.
- Returns a 40-bit frame built from register inputs (humidity, temperature, checksum).
- Used in loopback on the FPGA board and as a bus-functional target in reader simulations.

Parameters:
US_CYCLES, 50, clock cycles per microsecond (50 MHz).
START_MIN_US, 18000, minimum host low time accepted as a start request.
RESP_DELAY_US, 10, delay from host releasing the bus to emulator pulling low.
RESP_US, 80, duration of each of the response low and response high phases.
BIT_LOW_US, 50, low preamble before each bit and final end-of-frame low.
BIT0_HIGH_US, 26, high time encoding a 0.
BIT1_HIGH_US, 70, high time encoding a 1.

Ports:
clock  input  1  system clock.
reset_n  input  1  asynchronous, active-low reset.
dht_bus  inout  1  open-drain data line; emulator drives only 0 or z; external pull-up.
enable  input  1  1 = respond to host starts.
umidade  input  16  {integer, decimal} humidity bytes sent first.
temperatura  input  16  {integer, decimal} temperature bytes.
busy  output  1  high from start detection until bus release.
done  output  1  one-cycle pulse after frame completes.
db_estado  output  4  current state encoding, for debug.

Behaviour:
- Reset, asynchronous: state=IDLE, bus released (z), busy=0, done=0, all counters 0. Reset mid-frame releases the bus immediately; no partial bits are emitted after reset is deasserted.
- Bus input path: 2-flop synchronizer. Host timing is measured on the synchronized value, so it lags by 2 cycles.
- Single counter, width $clog2(START_MIN_US*US_CYCLES+1). It clears on every state change.
- Frame: {umidade[15:8], umidade[7:0], temperatura[15:8], temperatura[7:0], chk}, sent MSB first, bit 39 first.
  - chk = sum of the 4 bytes mod 256.
  - Frame is latched into a 40-bit shift register on the transition HOST_LOW->RESP_DELAY. Input changes mid-frame have no effect.
- States:
  - IDLE (0): waits for bus=0 with enable=1, then goes to HOST_LOW.
  - HOST_LOW (1): counts while bus=0.
    - Bus returns to 1 with count < START_MIN_US*US_CYCLES: back to IDLE, no response.
    - Bus returns to 1 with count >= threshold: go to RESP_DELAY.
    - Low held indefinitely: stay in HOST_LOW; the counter saturates.
  - RESP_DELAY (2): bus released for RESP_DELAY_US, then RESP_LOW.
  - RESP_LOW (3): drive 0 for RESP_US, then RESP_HIGH.
  - RESP_HIGH (4): release for RESP_US, then BIT_LOW.
  - BIT_LOW (5): drive 0 for BIT_LOW_US, then BIT_HIGH.
  - BIT_HIGH (6): release for BIT1_HIGH_US if the current bit is 1, else BIT0_HIGH_US.
    - Then shift the register and decrement the bit count.
    - Go to BIT_LOW if bits remain, else END_LOW.
  - END_LOW (7): drive 0 for BIT_LOW_US, then release, done=1 for one cycle, and go to IDLE.
- Phase durations are exact: N_US*US_CYCLES cycles each.
- busy=1 in states 1..7, except that HOST_LOW aborted below threshold never asserts busy. busy is registered and rises on the qualifying HOST_LOW exit.
- Bus activity is ignored in states 2..7, including host contention.
- enable=0 mid-frame: the frame still completes; new starts are blocked afterwards.
- A host low seen in IDLE while enable=0 is ignored entirely, even if enable rises during the pulse. The pulse must end before a new start is detected.

Optional Feature:
DHT11_CHKSUM_INJ_EN
- Defined: adds input port inject_err (1 bit), sampled at frame latch. When 1, the transmitted checksum is inverted (~chk), for exercising host error paths.
- Undefined: port absent; checksum is always correct.

Decomposition:
- Package dht11_pkg:
  - state localparams/enum (4-bit codes above);
  - default timing constants in microseconds;
  - checksum function (byte-sum mod 256).
  - The reader shares these constants.
- Sub-module dht11_bus_sync: 2-flop synchronizer plus registered rise/fall detect on dht_bus. Instantiated once.

Test Plan:
- umidade=16'h3700, temperatura=16'h1A05, host low 18 ms then release -> RESP_DELAY 500 cycles, 4000 low, 4000 high, then 40 bits with chk=8'h56 (bit 0 -> 1300 high cycles, bit 1 -> 3500 high cycles), final 2500-cycle low, done pulse, busy low.
- Host low 17.9 ms -> no bus drive, busy stays 0, state returns to IDLE.
- Loopback to dht11 reader with umidade=16'h5A01, temperatura=16'h1903 -> reader pronto=1, error=0, umidade=16'h5A01, temperatura=16'h1903.
- reset_n pulsed low during bit 20 -> bus z within the same cycle, state IDLE, done never pulses; next 18 ms start yields a full correct frame.
- enable=0 during host start -> no response; enable dropped mid-frame -> all 40 bits sent, done pulses.
- DHT11_CHKSUM_INJ_EN with inject_err=1, data 16'h3700/16'h1A05 -> checksum byte 8'hA9 on the bus.

Source files
------------

// File: rtl/dht11_pkg.sv
// dht11_pkg: shared definitions for the DHT11 single-wire protocol.
// Holds the state codes, the default timing in microseconds and the checksum helper.
// The reader and the sensor emulator both use these constants.
package dht11_pkg;

  // State codes; the numeric values appear on db_estado
  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_HOST_LOW   = 4'd1,
    ST_RESP_DELAY = 4'd2,
    ST_RESP_LOW   = 4'd3,
    ST_RESP_HIGH  = 4'd4,
    ST_BIT_LOW    = 4'd5,
    ST_BIT_HIGH   = 4'd6,
    ST_END_LOW    = 4'd7
  } dht11_state_e;

  // Default protocol timing, microseconds
  localparam int DHT11_US_CYCLES     = 50;
  localparam int DHT11_START_MIN_US  = 18000;
  localparam int DHT11_RESP_DELAY_US = 10;
  localparam int DHT11_RESP_US       = 80;
  localparam int DHT11_BIT_LOW_US    = 50;
  localparam int DHT11_BIT0_HIGH_US  = 26;
  localparam int DHT11_BIT1_HIGH_US  = 70;

  // Checksum byte: the four data bytes summed modulo 256
  function automatic logic [7:0] dht11_chksum(input logic [15:0] umid,
                                              input logic [15:0] temp);
    return umid[15:8] + umid[7:0] + temp[15:8] + temp[7:0];
  endfunction

endpackage

// File: rtl/dht11_bus_sync.sv
// dht11_bus_sync: two-flop synchronizer for the open-drain data line plus
// registered rise/fall pulses. Flops reset to 1 because an idle bus is pulled high.
module dht11_bus_sync (
  input  logic clock,
  input  logic reset_n,
  input  logic bus_in,
  output logic bus_rise,
  output logic bus_fall
);

  logic bus_meta;
  logic bus_sync;
  logic bus_prev;

  // Synchronize the line, keep the previous value, register one-cycle edge pulses
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus_meta <= 1'b1;
      bus_sync <= 1'b1;
      bus_prev <= 1'b1;
      bus_rise <= 1'b0;
      bus_fall <= 1'b0;
    end else begin
      bus_meta <= bus_in;
      bus_sync <= bus_meta;
      bus_prev <= bus_sync;
      bus_rise <= bus_sync & ~bus_prev;
      bus_fall <= ~bus_sync & bus_prev;
    end
  end

endmodule

// File: rtl/dht11_sensor_emu.sv
// dht11_sensor_emu: responder end of the DHT11 single-wire protocol.
// Waits for a long enough host low pulse, then answers with the response
// preamble and a 40-bit frame {umidade, temperatura, checksum}, MSB first.
// Optional build macro DHT11_CHKSUM_INJ_EN adds inject_err, which inverts
// the transmitted checksum of a frame when sampled high at frame latch.
//
// Host pulse timing is measured between the registered fall and rise pulses
// of the synchronizer, so both edges carry the same lag and the measured
// length equals the low time on the pin.
module dht11_sensor_emu
  import dht11_pkg::*;
#(
  parameter int US_CYCLES     = DHT11_US_CYCLES,
  parameter int START_MIN_US  = DHT11_START_MIN_US,
  parameter int RESP_DELAY_US = DHT11_RESP_DELAY_US,
  parameter int RESP_US       = DHT11_RESP_US,
  parameter int BIT_LOW_US    = DHT11_BIT_LOW_US,
  parameter int BIT0_HIGH_US  = DHT11_BIT0_HIGH_US,
  parameter int BIT1_HIGH_US  = DHT11_BIT1_HIGH_US
) (
  input  logic        clock,
  input  logic        reset_n,
  inout  wire         dht_bus,
  input  logic        enable,
  input  logic [15:0] umidade,
  input  logic [15:0] temperatura,
`ifdef DHT11_CHKSUM_INJ_EN
  input  logic        inject_err,
`endif
  output logic        busy,
  output logic        done,
  output logic [3:0]  db_estado
);

  localparam int CW = $clog2(START_MIN_US * US_CYCLES + 1);
  typedef logic [CW-1:0] cnt_t;

  // Each phase ends on the cycle the counter reaches its last value
  localparam cnt_t START_LAST = cnt_t'(START_MIN_US  * US_CYCLES - 1);
  localparam cnt_t DELAY_LAST = cnt_t'(RESP_DELAY_US * US_CYCLES - 1);
  localparam cnt_t RESP_LAST  = cnt_t'(RESP_US       * US_CYCLES - 1);
  localparam cnt_t BLOW_LAST  = cnt_t'(BIT_LOW_US    * US_CYCLES - 1);
  localparam cnt_t B0_LAST    = cnt_t'(BIT0_HIGH_US  * US_CYCLES - 1);
  localparam cnt_t B1_LAST    = cnt_t'(BIT1_HIGH_US  * US_CYCLES - 1);
  localparam cnt_t CNT_MAX    = {CW{1'b1}};

  dht11_state_e state;
  cnt_t         cnt;
  logic [39:0]  shreg;
  logic [5:0]   bit_cnt;
  logic         drive_low;
  logic         bus_rise;
  logic         bus_fall;
  logic [7:0]   chk;
  logic [7:0]   chk_tx;
  logic [39:0]  frame;

  dht11_bus_sync u_sync (
    .clock    (clock),
    .reset_n  (reset_n),
    .bus_in   (dht_bus),
    .bus_rise (bus_rise),
    .bus_fall (bus_fall)
  );

  // Open drain: pull low or let the external pull-up win
  assign dht_bus   = drive_low ? 1'b0 : 1'bz;
  assign db_estado = state;

  assign chk = dht11_chksum(umidade, temperatura);
`ifdef DHT11_CHKSUM_INJ_EN
  assign chk_tx = inject_err ? ~chk : chk;
`else
  assign chk_tx = chk;
`endif
  assign frame = {umidade, temperatura, chk_tx};

  // Protocol sequencer: host start qualification, response preamble, 40 bits, end low
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      drive_low <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          // Only a falling edge seen while enabled starts a measurement
          if (bus_fall && enable) state <= ST_HOST_LOW;
        end
        ST_HOST_LOW: begin
          if (bus_rise) begin
            cnt <= '0;
            if (cnt >= START_LAST) begin
              state   <= ST_RESP_DELAY;
              busy    <= 1'b1;
              shreg   <= frame;
              bit_cnt <= 6'd40;
            end else begin
              state <= ST_IDLE;
            end
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP_DELAY: begin
          if (cnt == DELAY_LAST) begin
            cnt       <= '0;
            state     <= ST_RESP_LOW;
            drive_low <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        ST_RESP_LOW: begin
          if (cnt == RESP_LAST) begin
            cnt       <= '0;
            state     <= ST_RESP_HIGH;
            drive_low <= 1'b0;
          end else cnt <= cnt + 1'b1;
        end
        ST_RESP_HIGH: begin
          if (cnt == RESP_LAST) begin
            cnt       <= '0;
            state     <= ST_BIT_LOW;
            drive_low <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        ST_BIT_LOW: begin
          if (cnt == BLOW_LAST) begin
            cnt       <= '0;
            state     <= ST_BIT_HIGH;
            drive_low <= 1'b0;
          end else cnt <= cnt + 1'b1;
        end
        ST_BIT_HIGH: begin
          if (cnt == (shreg[39] ? B1_LAST : B0_LAST)) begin
            cnt       <= '0;
            shreg     <= {shreg[38:0], 1'b0};
            bit_cnt   <= bit_cnt - 1'b1;
            drive_low <= 1'b1;
            state     <= (bit_cnt == 6'd1) ? ST_END_LOW : ST_BIT_LOW;
          end else cnt <= cnt + 1'b1;
        end
        ST_END_LOW: begin
          if (cnt == BLOW_LAST) begin
            cnt       <= '0;
            state     <= ST_IDLE;
            drive_low <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        default: begin
          cnt       <= '0;
          state     <= ST_IDLE;
          drive_low <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
